fp_simd_issuer: RTL and testbench

Command-side initiator for the FP_SIMD vector unit. It accepts one vector operation at a time over a valid/ready command port and drives FP_SIMD's enable, operand and opcode inputs. It waits for FP_SIMD to report completion, captures the result and returns it over a valid/ready response port. It sits between the shader/geometry sequencer and FP_SIMD, and replaces open-loop timed driving of the unit.

---
 rtl/fp_simd_issuer_pkg.sv | 21 ++
 rtl/fp_simd_issuer.sv | 120 ++++++++++++
 tb/tb_fp_simd_issuer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_simd_issuer_pkg.sv
// Shared 22-bit FP format (1 sign, 7 exponent, 14 mantissa, bias 63) and FP_SIMD opcodes.
package fp_simd_issuer_pkg;
    localparam int REN_FP_W  = 22;
    localparam int FP_EXP_W  = 7;
    localparam int FP_MANT_W = 14;
    localparam int FP_BIAS   = 63;

    localparam logic [2:0] op_add        = 3'd0;
    localparam logic [2:0] op_sub        = 3'd1;
    localparam logic [2:0] op_mul        = 3'd2;
    localparam logic [2:0] op_reduce_add = 3'd3;

    localparam logic [REN_FP_W-1:0] fpHALF      = {1'b0, 7'd62, 14'd0};
    localparam logic [REN_FP_W-1:0] fpONE       = {1'b0, 7'd63, 14'd0};
    localparam logic [REN_FP_W-1:0] fpONEHALF   = {1'b0, 7'd63, 14'd8192};
    localparam logic [REN_FP_W-1:0] fpTWO       = {1'b0, 7'd64, 14'd0};
    localparam logic [REN_FP_W-1:0] fpTWOHALF   = {1'b0, 7'd64, 14'd4096};
    localparam logic [REN_FP_W-1:0] fpTHREE     = {1'b0, 7'd64, 14'd8192};
    localparam logic [REN_FP_W-1:0] fpTHREEHALF = {1'b0, 7'd64, 14'd12288};
    localparam logic [REN_FP_W-1:0] fpFOUR      = {1'b0, 7'd65, 14'd0};
endpackage

// File: rtl/fp_simd_issuer.sv
// Closed-loop command issuer for FP_SIMD: one operation in flight, valid/ready on both sides,
// stale-valid rejection via an armed flag and a cycle timeout that returns an error response.
module fp_simd_issuer
    import fp_simd_issuer_pkg::*;
#(
    parameter int SIMD_WIDTH = 4,
    parameter int FP_W       = REN_FP_W,
    parameter int TIMEOUT    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [2:0]                 i_cmd_opcode,
    input  logic [SIMD_WIDTH*FP_W-1:0] i_cmd_a,
    input  logic [SIMD_WIDTH*FP_W-1:0] i_cmd_b,
    output logic                       o_simd_en,
    output logic [2:0]                 o_simd_opcode,
    output logic [SIMD_WIDTH*FP_W-1:0] o_simd_in1,
    output logic [SIMD_WIDTH*FP_W-1:0] o_simd_in2,
    input  logic [SIMD_WIDTH*FP_W-1:0] i_simd_output,
    input  logic                       i_simd_valid,
    input  logic                       i_simd_busy,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [SIMD_WIDTH*FP_W-1:0] o_rsp_data,
    output logic                       o_rsp_err
);
    localparam int VW    = SIMD_WIDTH * FP_W;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       opcode_reg, opcode_next;
    logic [VW-1:0]    a_reg, a_next;
    logic [VW-1:0]    b_reg, b_next;
    logic [VW-1:0]    data_reg, data_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             armed_reg, armed_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            opcode_reg <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            data_reg   <= '0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
            armed_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            opcode_reg <= opcode_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            data_reg   <= data_next;
            err_reg    <= err_next;
            cnt_reg    <= cnt_next;
            armed_reg  <= armed_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        opcode_next = opcode_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        data_next   = data_reg;
        err_next    = err_reg;
        cnt_next    = cnt_reg;
        armed_next  = armed_reg;
        case (state_reg)
            IDLE: begin
                if (i_cmd_valid) begin
                    opcode_next = i_cmd_opcode;
                    a_next      = i_cmd_a;
                    b_next      = i_cmd_b;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                armed_next = 1'b0;
                state_next = WAIT;
            end
            WAIT: begin
                // A valid seen before busy/idle-valid proves the unit restarted is a leftover.
                armed_next = armed_reg | i_simd_busy | ~i_simd_valid;
                if (armed_reg && i_simd_valid) begin
                    data_next  = i_simd_output;
                    err_next   = 1'b0;
                    state_next = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    data_next  = '0;
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode straight from the state register so reset removes them immediately.
    assign o_cmd_ready   = (state_reg == IDLE);
    assign o_simd_en     = (state_reg == ISSUE) || (state_reg == WAIT);
    assign o_rsp_valid   = (state_reg == RESP);
    assign o_simd_opcode = opcode_reg;
    assign o_simd_in1    = a_reg;
    assign o_simd_in2    = b_reg;
    assign o_rsp_data    = data_reg;
    assign o_rsp_err     = err_reg;
endmodule

// File: tb/tb_fp_simd_issuer.sv
// Bench for fp_simd_issuer with a behavioural FP_SIMD stand-in (real-valued lane arithmetic).
module tb_fp_simd_issuer;
    import fp_simd_issuer_pkg::*;

    localparam int SW = 4;
    localparam int W  = REN_FP_W;
    localparam int VW = SW * W;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [2:0]    i_cmd_opcode = '0;
    logic [VW-1:0] i_cmd_a = '0;
    logic [VW-1:0] i_cmd_b = '0;
    logic          o_simd_en;
    logic [2:0]    o_simd_opcode;
    logic [VW-1:0] o_simd_in1, o_simd_in2;
    logic [VW-1:0] simd_out = '0;
    logic          simd_valid = 1'b0;
    logic          simd_busy = 1'b0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b0;
    logic [VW-1:0] o_rsp_data;
    logic          o_rsp_err;

    int checks = 0;
    int errors = 0;
    logic ready_default = 1'b0;

    always #5 clk = ~clk;

    fp_simd_issuer #(.SIMD_WIDTH(SW), .FP_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_opcode(i_cmd_opcode),
        .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
        .o_simd_en(o_simd_en), .o_simd_opcode(o_simd_opcode),
        .o_simd_in1(o_simd_in1), .o_simd_in2(o_simd_in2),
        .i_simd_output(simd_out), .i_simd_valid(simd_valid), .i_simd_busy(simd_busy),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err)
    );

    function automatic real dec(input logic [W-1:0] x);
        real v;
        int  e;
        if (x[W-2:0] == '0) return 0.0;
        v = 1.0 + real'(x[FP_MANT_W-1:0]) / 16384.0;
        e = int'(x[W-2:FP_MANT_W]) - FP_BIAS;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return x[W-1] ? -v : v;
    endfunction

    function automatic logic [W-1:0] enc(input real v);
        logic s;
        int   e;
        real  m;
        if (v == 0.0) return '0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = FP_BIAS;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {s, 7'(e), 14'($rtoi((m - 1.0) * 16384.0))};
    endfunction

    function automatic logic [W-1:0] lane(input logic [VW-1:0] v, input int i);
        return v[(SW-1-i)*W +: W];
    endfunction

    // Lane-wise arithmetic on decoded values; reduce sums vector a into lane 0.
    function automatic logic [VW-1:0] fp_model(input logic [2:0] op, input logic [VW-1:0] a,
                                               input logic [VW-1:0] b);
        logic [VW-1:0] r;
        real acc, x, y;
        r = '0;
        acc = 0.0;
        for (int i = 0; i < SW; i++) begin
            x = dec(lane(a, i));
            y = dec(lane(b, i));
            case (op)
                op_add:        r[(SW-1-i)*W +: W] = enc(x + y);
                op_sub:        r[(SW-1-i)*W +: W] = enc(x - y);
                op_mul:        r[(SW-1-i)*W +: W] = enc(x * y);
                op_reduce_add: acc = acc + x;
                default: ;
            endcase
        end
        if (op == op_reduce_add) r[VW-1 -: W] = enc(acc);
        return r;
    endfunction

    // FP_SIMD stand-in: starts on rising enable, optional idle delay keeping the old valid up,
    // then busy for stub_lat cycles, then a sticky valid until the next start.
    logic          stub_dead = 1'b0;
    int            stub_delay = 0;
    int            stub_lat = 1;
    logic          en_d = 1'b0;
    logic          active = 1'b0;
    int            start_wait = 0;
    int            run_cnt = 0;
    logic [VW-1:0] res = '0;

    always @(posedge clk) begin
        en_d <= o_simd_en;
        if (o_simd_en && !en_d) begin
            res        <= fp_model(o_simd_opcode, o_simd_in1, o_simd_in2);
            run_cnt    <= stub_lat;
            start_wait <= stub_delay;
            active     <= !stub_dead;
            if (stub_dead) begin
                simd_valid <= 1'b0;
                simd_busy  <= 1'b0;
            end else if (stub_delay == 0) begin
                simd_busy  <= 1'b1;
                simd_valid <= 1'b0;
            end
        end else if (active) begin
            if (start_wait > 0) begin
                start_wait <= start_wait - 1;
                if (start_wait == 1) begin
                    simd_busy  <= 1'b1;
                    simd_valid <= 1'b0;
                end
            end else if (run_cnt > 1) begin
                run_cnt <= run_cnt - 1;
            end else begin
                simd_busy  <= 1'b0;
                simd_valid <= 1'b1;
                simd_out   <= res;
                active     <= 1'b0;
            end
        end
    end

    // Handshake one command, then wait for the response; wait_cycles counts ISSUE+WAIT cycles.
    task automatic send_cmd(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                            output logic [VW-1:0] data, output logic err,
                            output int wait_cycles, output bit en_bad);
        int n;
        n = 0;
        en_bad = 1'b0;
        @(negedge clk);
        while (!o_cmd_ready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!o_cmd_ready) begin
            errors++;
            $display("FAIL cmd_ready_wait: got %0b, required 1 within 100 cycles", o_cmd_ready);
        end
        i_cmd_valid = 1'b1; i_cmd_opcode = op; i_cmd_a = a; i_cmd_b = b;
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        wait_cycles = 0;
        @(negedge clk);
        while (!o_rsp_valid && wait_cycles < 100) begin
            if (!o_simd_en) en_bad = 1'b1;
            wait_cycles++;
            @(negedge clk);
        end
        checks++;
        if (!o_rsp_valid) begin
            errors++;
            $display("FAIL rsp_valid_wait: got %0b, required 1 within 100 cycles", o_rsp_valid);
        end
        if (o_simd_en) en_bad = 1'b1;
        data = o_rsp_data;
        err  = o_rsp_err;
        $display("txn op=%0d data=%h err=%0b cycles=%0d", op, data, err, wait_cycles);
    endtask

    task automatic release_rsp();
        i_rsp_ready = 1'b1;
        @(posedge clk);
        #1 i_rsp_ready = ready_default;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({o_cmd_ready, o_simd_en, o_rsp_valid, o_rsp_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/en/vld/err=%b, required 1000",
                     {o_cmd_ready, o_simd_en, o_rsp_valid, o_rsp_err});
        end
        checks++;
        if ({o_rsp_data, o_simd_in1, o_simd_in2, o_simd_opcode} !== '0) begin
            errors++;
            $display("FAIL reset_data: got data=%h in1=%h in2=%h op=%0d, required all 0",
                     o_rsp_data, o_simd_in1, o_simd_in2, o_simd_opcode);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_cmd_ready !== 1'b1 || o_simd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got rdy=%0b en=%0b, required rdy=1 en=0",
                     o_cmd_ready, o_simd_en);
        end
    endtask

    task automatic test_add();
        logic [VW-1:0] d, exp_d;
        logic e;
        int c;
        bit bad;
        stub_delay = 0; stub_lat = 1;
        exp_d = {fpONEHALF, fpFOUR, fpTHREEHALF, fpFOUR};
        send_cmd(op_add, {fpONE, fpTWO, fpTWOHALF, fpTHREE}, {fpHALF, fpTWO, fpONE, fpONE},
                 d, e, c, bad);
        checks++;
        if (d !== exp_d || e !== 1'b0) begin
            errors++;
            $display("FAIL add_data: got %h err=%0b, required %h err=0", d, e, exp_d);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL add_en_window: got en outside ISSUE..capture, required high only there");
        end
        checks++;
        if (c !== 3) begin
            errors++;
            $display("FAIL add_latency: got %0d cycles, required 3", c);
        end
        release_rsp();
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] dm, ds, exp_m, exp_s, a, b;
        logic e;
        int c;
        bit bad;
        a = {fpONE, fpTWO, fpTWOHALF, fpTHREE};
        b = {fpHALF, fpTWO, fpONE, fpONE};
        exp_m = {fpHALF, fpFOUR, fpTWOHALF, fpTHREE};
        exp_s = {fpHALF, 22'd0, fpONEHALF, fpTWO};
        ready_default = 1'b1;
        i_rsp_ready = 1'b1;
        stub_delay = 0; stub_lat = 2;
        send_cmd(op_mul, a, b, dm, e, c, bad);
        release_rsp();
        stub_delay = 2;
        send_cmd(op_sub, a, b, ds, e, c, bad);
        release_rsp();
        ready_default = 1'b0;
        i_rsp_ready = 1'b0;
        checks++;
        if (dm !== exp_m) begin
            errors++;
            $display("FAIL b2b_mul: got %h, required %h", dm, exp_m);
        end
        checks++;
        if (ds !== exp_s || e !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sub_not_stale: got %h err=%0b, required %h err=0", ds, e, exp_s);
        end
    endtask

    task automatic test_reduce();
        logic [VW-1:0] d;
        logic e;
        int c;
        bit bad;
        stub_delay = 1; stub_lat = 2;
        send_cmd(op_reduce_add, {fpONEHALF, fpHALF, fpONE, fpONE}, '0, d, e, c, bad);
        checks++;
        if (lane(d, 0) !== fpFOUR || e !== 1'b0) begin
            errors++;
            $display("FAIL reduce_lane0: got %h err=%0b, required %h err=0", lane(d, 0), e, fpFOUR);
        end
        release_rsp();
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] d, a, b;
        logic e;
        int c;
        bit bad, hold_bad;
        a = {fpTWO, fpTHREE, fpHALF, fpONE};
        b = {fpONE, fpONE, fpTWO, fpHALF};
        stub_delay = 1; stub_lat = 3;
        send_cmd(op_add, a, b, d, e, c, bad);
        i_cmd_valid = 1'b1; i_cmd_opcode = op_mul; i_cmd_a = b; i_cmd_b = a;
        hold_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_rsp_data !== d || o_rsp_valid !== 1'b1 || o_cmd_ready !== 1'b0 ||
                o_simd_en !== 1'b0 || o_rsp_err !== e)
                hold_bad = 1'b1;
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL bp_hold: got data=%h vld=%0b rdy=%0b en=%0b, required data=%h vld=1 rdy=0 en=0",
                     o_rsp_data, o_rsp_valid, o_cmd_ready, o_simd_en, d);
        end
        checks++;
        if (o_simd_opcode !== op_add || o_simd_in1 !== a) begin
            errors++;
            $display("FAIL bp_cmd_ignored: got op=%0d in1=%h, required op=%0d in1=%h",
                     o_simd_opcode, o_simd_in1, op_add, a);
        end
        i_cmd_valid = 1'b0;
        release_rsp();
        @(negedge clk);
        checks++;
        if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept_idle: got rdy=%0b vld=%0b, required rdy=1 vld=0",
                     o_cmd_ready, o_rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] d, a, b, exp_d;
        logic e;
        int c, n;
        bit bad;
        a = {fpTHREE, fpTWO, fpONE, fpHALF};
        b = {fpONE, fpHALF, fpHALF, fpTWO};
        stub_delay = 0; stub_lat = 3;
        n = 0;
        @(negedge clk);
        while (!o_cmd_ready && n < 100) begin @(negedge clk); n++; end
        i_cmd_valid = 1'b1; i_cmd_opcode = op_mul; i_cmd_a = a; i_cmd_b = b;
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({o_cmd_ready, o_simd_en, o_rsp_valid, o_rsp_err} !== 4'b1000 ||
            {o_rsp_data, o_simd_in1, o_simd_in2, o_simd_opcode} !== '0) begin
            errors++;
            $display("FAIL rst_mid: got rdy/en/vld/err=%b data=%h in1=%h, required 1000 and zeros",
                     {o_cmd_ready, o_simd_en, o_rsp_valid, o_rsp_err}, o_rsp_data, o_simd_in1);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        stub_delay = 1; stub_lat = 2;
        exp_d = fp_model(op_add, a, b);
        send_cmd(op_add, a, b, d, e, c, bad);
        checks++;
        if (d !== exp_d || e !== 1'b0) begin
            errors++;
            $display("FAIL rst_recover: got %h err=%0b, required %h err=0", d, e, exp_d);
        end
        release_rsp();
    endtask

    task automatic test_timeout();
        logic [VW-1:0] d;
        logic e;
        int c;
        bit bad;
        stub_dead = 1'b1;
        send_cmd(op_add, {fpONE, fpONE, fpONE, fpONE}, {fpTWO, fpTWO, fpTWO, fpTWO}, d, e, c, bad);
        checks++;
        if (e !== 1'b1 || d !== '0) begin
            errors++;
            $display("FAIL timeout_rsp: got data=%h err=%0b, required data=0 err=1", d, e);
        end
        checks++;
        if (c !== 1 + TO) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d ISSUE+WAIT cycles, required %0d", c, 1 + TO);
        end
        release_rsp();
        stub_dead = 1'b0;
    endtask

    task automatic test_random();
        real vals[6] = '{0.5, 1.0, 1.5, 2.0, 2.5, 3.0};
        logic [VW-1:0] a, b, d, exp_q[$];
        logic [2:0] op;
        logic e;
        int c, hold;
        bit bad;
        for (int t = 0; t < 20; t++) begin
            op = 3'($urandom_range(0, 3));
            for (int i = 0; i < SW; i++) begin
                a[(SW-1-i)*W +: W] = enc(vals[$urandom_range(0, 5)]);
                b[(SW-1-i)*W +: W] = enc(vals[$urandom_range(0, 5)]);
            end
            stub_delay = $urandom_range(0, 2);
            stub_lat   = $urandom_range(1, 3);
            hold       = $urandom_range(0, 3);
            exp_q.push_back(fp_model(op, a, b));
            send_cmd(op, a, b, d, e, c, bad);
            repeat (hold) @(negedge clk);
            checks++;
            if (o_rsp_data !== d) begin
                errors++;
                $display("FAIL rand_hold[%0d]: got %h, required %h", t, o_rsp_data, d);
            end
            release_rsp();
            checks++;
            if (op == op_reduce_add) begin
                if (lane(d, 0) !== lane(exp_q[0], 0) || e !== 1'b0 || bad) begin
                    errors++;
                    $display("FAIL rand_reduce[%0d]: got %h err=%0b en_bad=%0b, required %h err=0",
                             t, lane(d, 0), e, bad, lane(exp_q[0], 0));
                end
            end else if (d !== exp_q[0] || e !== 1'b0 || bad) begin
                errors++;
                $display("FAIL rand_op[%0d]: got %h err=%0b en_bad=%0b, required %h err=0",
                         t, d, e, bad, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_reduce();
        test_backpressure();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, required completion");
        $fatal(1);
    end
endmodule
